// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared state encodings and nibble width for the serial adder.
package nibble_serial_add_ctrl_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   function automatic int idx_w(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction
endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: combinational 4-bit add-with-carry slice.
module nibble_add4
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add, one nibble per cycle LSB first, valid/ready on both sides.
// Define SUBTRACT_EN to add the in_op port (1 = A-B, out_cout=1 means no borrow).
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef SUBTRACT_EN
   input  logic             in_op,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);
   localparam int NIB = WIDTH / NIBBLE_W;
   localparam int IW  = idx_w(NIB);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic                 c_q, c_d, cout_q, cout_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 accept, last, sub, carry_init;
   logic [NIBBLE_W-1:0]  a_nib, b_nib, s_nib;
   logic                 c_nib;

`ifdef SUBTRACT_EN
   logic op_q, op_d;
   assign sub        = op_q;
   assign carry_init = in_op ? 1'b1 : in_cin;
   assign op_d       = accept ? in_op : op_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) op_q <= 1'b0;
      else        op_q <= op_d;
`else
   assign sub        = 1'b0;
   assign carry_init = in_cin;
`endif

   assign accept = in_valid && in_ready;
   assign last   = idx_q == IW'(NIB - 1);
   // Subtract is A + ~B + 1: invert B nibbles here, the +1 enters via carry_init.
   assign a_nib  = a_q[{idx_q, 2'b00} +: NIBBLE_W];
   assign b_nib  = b_q[{idx_q, 2'b00} +: NIBBLE_W] ^ {NIBBLE_W{sub}};

   nibble_add4 u_add (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (c_q),
      .sum  (s_nib),
      .cout (c_nib)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: state_d = accept ? ST_RUN : ST_IDLE;
         ST_RUN:  state_d = last ? ST_DONE : ST_RUN;
         ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      idx_d  = idx_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      if (accept) begin
         a_d   = in_a;
         b_d   = in_b;
         c_d   = carry_init;
         idx_d = '0;
      end else if (state_q == ST_RUN) begin
         sum_d[{idx_q, 2'b00} +: NIBBLE_W] = s_nib;
         c_d    = c_nib;
         idx_d  = last ? idx_q : idx_q + 1'b1;
         cout_d = last ? c_nib : cout_q;
      end
   end

   // in_ready is gated by rst_n so it reads 0 throughout reset.
   always_comb begin
      in_ready  = rst_n && (state_q == ST_IDLE);
      out_valid = state_q == ST_DONE;
      busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
      out_sum   = sum_q;
      out_cout  = cout_q;
   end
endmodule
